// File: rtl/led_driver_rx.sv
// led_driver_rx: receiver model of one serial LED-driver lane.
// Synchronizes the interface inputs to the system clock and detects their
// rising edges. Shifts serial frames in and latches grayscale or
// dot-correction data on XLAT. Runs the grayscale PWM counter from GSCLK
// and reports per-channel on/off state.
module led_driver_rx #(
    parameter int CHANNELS    = 16,
    parameter int GS_BITS     = 12,
    parameter int DC_BITS     = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                led_sclk,
    input  logic                led_sin,
    input  logic                led_xlat,
    input  logic                led_blank,
    input  logic                led_mode,
    input  logic                led_gsclk,
    output logic                led_sout,
    output logic [CHANNELS-1:0] channel_on,
    input  logic [3:0]          rd_sel,
    output logic [GS_BITS-1:0]  rd_gs,
    output logic [DC_BITS-1:0]  rd_dc,
    output logic                frame_err,
    output logic [7:0]          xlat_count
);
    localparam int SHIFT_W = CHANNELS * GS_BITS;
    localparam int DC_W    = CHANNELS * DC_BITS;

    // Bit positions of the six interface inputs inside the synchronizer word
    localparam int I_SCLK  = 0;
    localparam int I_SIN   = 1;
    localparam int I_XLAT  = 2;
    localparam int I_BLANK = 3;
    localparam int I_MODE  = 4;
    localparam int I_GSCLK = 5;

    logic [5:0] in_raw;
    logic [5:0] sync_d [SYNC_STAGES];
    logic [5:0] sync_q [SYNC_STAGES];
    logic [5:0] prev_d, prev_q;
    logic [5:0] in_sync, in_rise;

    logic [SHIFT_W-1:0]  shift_d, shift_q;
    logic [7:0]          bit_count_d, bit_count_q;
    logic [GS_BITS-1:0]  gs_d [CHANNELS];
    logic [GS_BITS-1:0]  gs_q [CHANNELS];
    logic [DC_BITS-1:0]  dc_d [CHANNELS];
    logic [DC_BITS-1:0]  dc_q [CHANNELS];
    logic                frame_err_d, frame_err_q;
    logic [7:0]          xlat_count_d, xlat_count_q;
    logic                led_sout_d, led_sout_q;
    logic [GS_BITS-1:0]  gs_cnt_d, gs_cnt_q;
    logic [CHANNELS-1:0] channel_on_d, channel_on_q;

    logic sclk_rise, xlat_rise, gsclk_rise, sin_s, mode_s, blank_s;

    assign in_raw = {led_gsclk, led_mode, led_blank, led_xlat, led_sin, led_sclk};

    // Synchronizer chain and edge-detect history; every input gets equal
    // depth so SIN and MODE stay aligned with the SCLK and XLAT edges.
    always_comb begin
        sync_d[0] = in_raw;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
        prev_d = in_sync;
    end

    assign in_sync    = sync_q[SYNC_STAGES-1];
    assign in_rise    = in_sync & ~prev_q;
    assign sclk_rise  = in_rise[I_SCLK];
    assign xlat_rise  = in_rise[I_XLAT];
    assign gsclk_rise = in_rise[I_GSCLK];
    assign sin_s      = in_sync[I_SIN];
    assign mode_s     = in_sync[I_MODE];
    assign blank_s    = in_sync[I_BLANK];

    // Frame shift, bit counting and XLAT latching. The latch reads shift_q,
    // so a coincident SCLK bit is excluded and starts the next frame.
    always_comb begin
        shift_d      = shift_q;
        bit_count_d  = bit_count_q;
        gs_d         = gs_q;
        dc_d         = dc_q;
        frame_err_d  = frame_err_q;
        xlat_count_d = xlat_count_q;
        if (xlat_rise) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (mode_s) begin
                    dc_d[i] = shift_q[i*DC_BITS +: DC_BITS];
                end else begin
                    gs_d[i] = shift_q[i*GS_BITS +: GS_BITS];
                end
            end
            frame_err_d  = (bit_count_q != (mode_s ? 8'(DC_W) : 8'(SHIFT_W)));
            xlat_count_d = xlat_count_q + 8'd1;
            bit_count_d  = 8'd0;
        end
        if (sclk_rise) begin
            shift_d = {shift_q[SHIFT_W-2:0], sin_s};
            if (xlat_rise) begin
                bit_count_d = 8'd1;
            end else if (bit_count_q != 8'hFF) begin
                bit_count_d = bit_count_q + 8'd1;
            end
        end
        led_sout_d = shift_q[SHIFT_W-1];
    end

    // Grayscale PWM counter and per-channel compare
    always_comb begin
        gs_cnt_d = gs_cnt_q;
        if (blank_s) begin
            gs_cnt_d = '0;
        end else if (gsclk_rise && (gs_cnt_q != {GS_BITS{1'b1}})) begin
            gs_cnt_d = gs_cnt_q + {{(GS_BITS-1){1'b0}}, 1'b1};
        end
        for (int i = 0; i < CHANNELS; i++) begin
            channel_on_d[i] = !blank_s && (gs_cnt_q < gs_q[i]);
        end
    end

    // State registers; reset clears partial frames and latched data at once
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            prev_q <= '0;
            shift_q <= '0;
            bit_count_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                gs_q[i] <= '0;
                dc_q[i] <= '0;
            end
            frame_err_q <= 1'b0;
            xlat_count_q <= '0;
            led_sout_q <= 1'b0;
            gs_cnt_q <= '0;
            channel_on_q <= '0;
        end else begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_d[k];
            end
            prev_q <= prev_d;
            shift_q <= shift_d;
            bit_count_q <= bit_count_d;
            for (int i = 0; i < CHANNELS; i++) begin
                gs_q[i] <= gs_d[i];
                dc_q[i] <= dc_d[i];
            end
            frame_err_q <= frame_err_d;
            xlat_count_q <= xlat_count_d;
            led_sout_q <= led_sout_d;
            gs_cnt_q <= gs_cnt_d;
            channel_on_q <= channel_on_d;
        end
    end

    assign led_sout   = led_sout_q;
    assign channel_on = channel_on_q;
    assign frame_err  = frame_err_q;
    assign xlat_count = xlat_count_q;
    assign rd_gs      = gs_q[rd_sel];
    assign rd_dc      = dc_q[rd_sel];
endmodule

// File: tb/tb_led_driver_rx.sv
// Directed bench for led_driver_rx: frame loading, frame errors, DC frames,
// PWM compare, blanking, coincident SCLK/XLAT and asynchronous reset.
module tb_led_driver_rx;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        led_sclk = 1'b0;
    logic        led_sin = 1'b0;
    logic        led_xlat = 1'b0;
    logic        led_blank = 1'b0;
    logic        led_mode = 1'b0;
    logic        led_gsclk = 1'b0;
    logic        led_sout;
    logic [15:0] channel_on;
    logic [3:0]  rd_sel = 4'd0;
    logic [11:0] rd_gs;
    logic [5:0]  rd_dc;
    logic        frame_err;
    logic [7:0]  xlat_count;

    int total = 0;
    int bad = 0;

    led_driver_rx dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .led_sclk   (led_sclk),
        .led_sin    (led_sin),
        .led_xlat   (led_xlat),
        .led_blank  (led_blank),
        .led_mode   (led_mode),
        .led_gsclk  (led_gsclk),
        .led_sout   (led_sout),
        .channel_on (channel_on),
        .rd_sel     (rd_sel),
        .rd_gs      (rd_gs),
        .rd_dc      (rd_dc),
        .frame_err  (frame_err),
        .xlat_count (xlat_count)
    );

    // Clock generation
    always #5 clock = ~clock;

    // Advance n clocks and land 1 ns after the last rising edge
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Send the low n bits of v, most significant first
    task automatic send_bits(input logic [191:0] v, input int n);
        for (int b = n - 1; b >= 0; b--) begin
            led_sin = v[b];
            tick(4);
            led_sclk = 1'b1;
            tick(4);
            led_sclk = 1'b0;
        end
        tick(4);
    endtask

    task automatic pulse_xlat();
        led_xlat = 1'b1;
        tick(4);
        led_xlat = 1'b0;
        tick(6);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick(2);
        total++;
        if ({led_sout, channel_on, frame_err, xlat_count} !== 26'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0", {led_sout, channel_on, frame_err, xlat_count});
        end
        for (int s = 0; s < 16; s++) begin
            rd_sel = s[3:0];
            #1;
            total++;
            if ({rd_gs, rd_dc} !== 18'd0) begin
                bad++;
                $display("FAIL reset_rd sel=%0d gs=%h dc=%h want=0", s, rd_gs, rd_dc);
            end
        end
    endtask

    task automatic test_gs_frame();
        logic [191:0] v;
        for (int i = 0; i < 16; i++) v[i*12 +: 12] = 12'h001;
        v[15*12 +: 12] = 12'hABC;
        send_bits(v, 192);
        total++;
        if (led_sout !== 1'b1) begin
            bad++;
            $display("FAIL gs_sout got=%b want=1", led_sout);
        end
        pulse_xlat();
        rd_sel = 4'd15; #1;
        total++;
        if (rd_gs !== 12'hABC) begin bad++; $display("FAIL gs_ch15 got=%h want=abc", rd_gs); end
        rd_sel = 4'd0; #1;
        total++;
        if (rd_gs !== 12'h001) begin bad++; $display("FAIL gs_ch0 got=%h want=001", rd_gs); end
        rd_sel = 4'd7; #1;
        total++;
        if (rd_gs !== 12'h001) begin bad++; $display("FAIL gs_ch7 got=%h want=001", rd_gs); end
        total++;
        if (frame_err !== 1'b0) begin bad++; $display("FAIL gs_frame_err got=%b want=0", frame_err); end
        total++;
        if (xlat_count !== 8'd1) begin bad++; $display("FAIL gs_xlat_count got=%0d want=1", xlat_count); end
        // Every channel has a nonzero value, so all outputs are on at count 0
        total++;
        if (channel_on !== 16'hFFFF) begin bad++; $display("FAIL gs_channel_on got=%h want=ffff", channel_on); end
    endtask

    task automatic test_short_frame();
        logic [191:0] v;
        v = '0;
        v[0 +: 12] = 12'h555;
        v[15*12 +: 12] = 12'h123;
        // 191 bits: top bit comes from the previous frame's bit 0 (a 1)
        send_bits(v, 191);
        pulse_xlat();
        total++;
        if (frame_err !== 1'b1) begin bad++; $display("FAIL short_frame_err got=%b want=1", frame_err); end
        rd_sel = 4'd15; #1;
        total++;
        if (rd_gs !== 12'h923) begin bad++; $display("FAIL short_ch15 got=%h want=923", rd_gs); end
        rd_sel = 4'd0; #1;
        total++;
        if (rd_gs !== 12'h555) begin bad++; $display("FAIL short_ch0 got=%h want=555", rd_gs); end
        for (int i = 0; i < 16; i++) v[i*12 +: 12] = {i[3:0], 8'h5A};
        send_bits(v, 192);
        pulse_xlat();
        total++;
        if (frame_err !== 1'b0) begin bad++; $display("FAIL full_frame_err got=%b want=0", frame_err); end
        rd_sel = 4'd15; #1;
        total++;
        if (rd_gs !== 12'hF5A) begin bad++; $display("FAIL full_ch15 got=%h want=f5a", rd_gs); end
        total++;
        if (xlat_count !== 8'd3) begin bad++; $display("FAIL full_xlat_count got=%0d want=3", xlat_count); end
    endtask

    task automatic test_dc_frame();
        logic [191:0] v;
        v = '0;
        for (int i = 0; i < 16; i++) v[i*6 +: 6] = i[5:0];
        v[3*6 +: 6] = 6'h2A;
        led_mode = 1'b1;
        tick(4);
        send_bits(v, 96);
        pulse_xlat();
        led_mode = 1'b0;
        tick(4);
        rd_sel = 4'd3; #1;
        total++;
        if (rd_dc !== 6'h2A) begin bad++; $display("FAIL dc_ch3 got=%h want=2a", rd_dc); end
        rd_sel = 4'd5; #1;
        total++;
        if (rd_dc !== 6'h05) begin bad++; $display("FAIL dc_ch5 got=%h want=05", rd_dc); end
        rd_sel = 4'd15; #1;
        total++;
        if (rd_gs !== 12'hF5A) begin bad++; $display("FAIL dc_gs_kept got=%h want=f5a", rd_gs); end
        total++;
        if (frame_err !== 1'b0) begin bad++; $display("FAIL dc_frame_err got=%b want=0", frame_err); end
        total++;
        if (xlat_count !== 8'd4) begin bad++; $display("FAIL dc_xlat_count got=%0d want=4", xlat_count); end
    endtask

    task automatic test_pwm();
        logic [191:0] v;
        logic [15:0]  want;
        v = '0;
        v[0*12 +: 12] = 12'd3;
        v[1*12 +: 12] = 12'd0;
        v[2*12 +: 12] = 12'd4095;
        send_bits(v, 192);
        pulse_xlat();
        led_blank = 1'b1;
        tick(6);
        led_blank = 1'b0;
        tick(6);
        for (int n = 0; n <= 5000; n++) begin
            if (n > 0) begin
                led_gsclk = 1'b1;
                tick(3);
                led_gsclk = 1'b0;
                tick(4);
            end
            want = '0;
            want[0] = (n < 3);
            want[2] = (n < 4095);
            total++;
            if (channel_on !== want) begin
                bad++;
                $display("FAIL pwm count=%0d got=%h want=%h", n, channel_on, want);
            end
        end
        led_blank = 1'b1;
        tick(5);
        total++;
        if (channel_on !== 16'h0000) begin bad++; $display("FAIL blank_off got=%h want=0000", channel_on); end
        led_blank = 1'b0;
        tick(5);
        // Counter back at 0: channels 0 and 2 on, channel 1 off
        total++;
        if (channel_on !== 16'h0005) begin bad++; $display("FAIL blank_cleared got=%h want=0005", channel_on); end
    endtask

    task automatic test_back_to_back();
        logic [191:0] f;
        logic [191:0] g;
        for (int i = 0; i < 16; i++) begin
            f[i*12 +: 12] = 12'h300 + 12'(i);
            g[i*12 +: 12] = 12'hA00 + 12'(i);
        end
        send_bits(f, 192);
        // First bit of g shifts in on the same cycle that XLAT latches f
        led_sin = g[191];
        tick(4);
        led_sclk = 1'b1;
        led_xlat = 1'b1;
        tick(4);
        led_sclk = 1'b0;
        led_xlat = 1'b0;
        tick(6);
        rd_sel = 4'd15; #1;
        total++;
        if (rd_gs !== 12'h30F) begin bad++; $display("FAIL coincident_ch15 got=%h want=30f", rd_gs); end
        total++;
        if (frame_err !== 1'b0) begin bad++; $display("FAIL coincident_err got=%b want=0", frame_err); end
        total++;
        if (xlat_count !== 8'd6) begin bad++; $display("FAIL coincident_xlat_count got=%0d want=6", xlat_count); end
        send_bits(g, 191);
        pulse_xlat();
        total++;
        if (frame_err !== 1'b0) begin bad++; $display("FAIL next_frame_err got=%b want=0", frame_err); end
        rd_sel = 4'd15; #1;
        total++;
        if (rd_gs !== 12'hA0F) begin bad++; $display("FAIL next_ch15 got=%h want=a0f", rd_gs); end
        rd_sel = 4'd7; #1;
        total++;
        if (rd_gs !== 12'hA07) begin bad++; $display("FAIL next_ch7 got=%h want=a07", rd_gs); end
    endtask

    task automatic test_reset_mid_frame();
        logic [191:0] v;
        v = {192{1'b1}};
        send_bits(v, 50);
        #3;
        reset_n = 1'b0;
        #1;
        rd_sel = 4'd15; #1;
        total++;
        if ({rd_gs, xlat_count, channel_on, led_sout} !== 37'd0) begin
            bad++;
            $display("FAIL async_reset got=%h want=0", {rd_gs, xlat_count, channel_on, led_sout});
        end
        tick(2);
        reset_n = 1'b1;
        tick(3);
    endtask

    initial begin
        test_reset();
        test_gs_frame();
        test_short_frame();
        test_dc_frame();
        test_pwm();
        test_back_to_back();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
